// File: rtl/k007452_arith_seq_if.sv
// Request/result bundle for the shared serial multiply/divide sequencer.
// The master drives requests and operands; the slave returns handshakes and results.
interface k007452_arith_seq_if #(
    parameter int W = 8
);
    logic           REQ_A;
    logic           OP_A;
    logic [2*W-1:0] X_A;
    logic [W-1:0]   Y_A;
    logic           REQ_B;
    logic           OP_B;
    logic [2*W-1:0] X_B;
    logic [W-1:0]   Y_B;
    logic           ACK_A;
    logic           ACK_B;
    logic           DONE_A;
    logic           DONE_B;
    logic [2*W-1:0] RQ;
    logic [W-1:0]   RR;
    logic           DZ;
    logic           BUSY;

    modport master (
        output REQ_A, OP_A, X_A, Y_A, REQ_B, OP_B, X_B, Y_B,
        input  ACK_A, ACK_B, DONE_A, DONE_B, RQ, RR, DZ, BUSY
    );

    modport slave (
        input  REQ_A, OP_A, X_A, Y_A, REQ_B, OP_B, X_B, Y_B,
        output ACK_A, ACK_B, DONE_A, DONE_B, RQ, RR, DZ, BUSY
    );
endinterface

// File: rtl/k007452_arith_seq.sv
// Round-robin sequencer sharing one bit-serial shift-add multiplier / restoring
// divider between two requesters; one datapath iteration per clock.
module k007452_arith_seq #(
    parameter int W = 8
) (
    input  logic               CLK,
    input  logic               RES,
    k007452_arith_seq_if.slave bus
);
    localparam int CW = $clog2(2 * W);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state_reg, state_next;
    logic           last_served_reg, last_served_next;  // 0 = A, 1 = B
    logic           owner_reg, owner_next;
    logic           op_reg, op_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic [2*W-1:0] acc_reg, acc_next;      // mul accumulator / div dividend->quotient shifter
    logic [2*W-1:0] mcand_reg, mcand_next;  // multiplicand, shifted left each iteration
    logic [W-1:0]   y_reg, y_next;          // multiplier (shifted right) or divisor
    logic [W-1:0]   rem_reg, rem_next;
    logic [2*W-1:0] rq_reg, rq_next;
    logic [W-1:0]   rr_reg, rr_next;
    logic           dz_reg, dz_next;
    logic           ack_a_reg, ack_a_next;
    logic           ack_b_reg, ack_b_next;
    logic           done_a_reg, done_a_next;
    logic           done_b_reg, done_b_next;

    logic           pick_b;
    logic           sel_op;
    logic [2*W-1:0] sel_x;
    logic [W-1:0]   sel_y;
    logic [W:0]     trial;
    logic           fits;
    logic [W-1:0]   diff;
    logic [W-1:0]   div_rem;
    logic [2*W-1:0] div_quot;
    logic [2*W-1:0] mul_sum;

    // On a tie the requester that was not served last wins.
    assign pick_b = bus.REQ_B && (!bus.REQ_A || !last_served_reg);
    assign sel_op = pick_b ? bus.OP_B : bus.OP_A;
    assign sel_x  = pick_b ? bus.X_B  : bus.X_A;
    assign sel_y  = pick_b ? bus.Y_B  : bus.Y_A;

    // Restoring step: the difference is only kept when it fits, so W bits suffice.
    assign trial    = {rem_reg, acc_reg[2*W-1]};
    assign fits     = (trial >= {1'b0, y_reg});
    assign diff     = trial[W-1:0] - y_reg;
    assign div_rem  = fits ? diff : trial[W-1:0];
    assign div_quot = {acc_reg[2*W-2:0], fits};
    assign mul_sum  = acc_reg + (y_reg[0] ? mcand_reg : '0);

    always_ff @(posedge CLK) begin
        if (RES) begin
            state_reg       <= IDLE;
            last_served_reg <= 1'b1;
            owner_reg       <= 1'b0;
            op_reg          <= 1'b0;
            cnt_reg         <= '0;
            acc_reg         <= '0;
            mcand_reg       <= '0;
            y_reg           <= '0;
            rem_reg         <= '0;
            rq_reg          <= '0;
            rr_reg          <= '0;
            dz_reg          <= 1'b0;
            ack_a_reg       <= 1'b0;
            ack_b_reg       <= 1'b0;
            done_a_reg      <= 1'b0;
            done_b_reg      <= 1'b0;
        end else begin
            state_reg       <= state_next;
            last_served_reg <= last_served_next;
            owner_reg       <= owner_next;
            op_reg          <= op_next;
            cnt_reg         <= cnt_next;
            acc_reg         <= acc_next;
            mcand_reg       <= mcand_next;
            y_reg           <= y_next;
            rem_reg         <= rem_next;
            rq_reg          <= rq_next;
            rr_reg          <= rr_next;
            dz_reg          <= dz_next;
            ack_a_reg       <= ack_a_next;
            ack_b_reg       <= ack_b_next;
            done_a_reg      <= done_a_next;
            done_b_reg      <= done_b_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        last_served_next = last_served_reg;
        owner_next       = owner_reg;
        op_next          = op_reg;
        cnt_next         = cnt_reg;
        acc_next         = acc_reg;
        mcand_next       = mcand_reg;
        y_next           = y_reg;
        rem_next         = rem_reg;
        rq_next          = rq_reg;
        rr_next          = rr_reg;
        dz_next          = dz_reg;
        ack_a_next       = 1'b0;
        ack_b_next       = 1'b0;
        done_a_next      = 1'b0;
        done_b_next      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.REQ_A || bus.REQ_B) begin
                    last_served_next = pick_b;
                    owner_next       = pick_b;
                    op_next          = sel_op;
                    y_next           = sel_y;
                    ack_a_next       = !pick_b;
                    ack_b_next       = pick_b;
                    if (!sel_op) begin
                        acc_next   = '0;
                        mcand_next = {{W{1'b0}}, sel_x[W-1:0]};
                        cnt_next   = CW'(W - 1);
                        state_next = RUN;
                    end else if (sel_y != '0) begin
                        acc_next   = sel_x;
                        rem_next   = '0;
                        cnt_next   = CW'(2 * W - 1);
                        state_next = RUN;
                    end else begin
                        // Divide by zero completes immediately with saturated results.
                        rq_next     = '1;
                        rr_next     = '1;
                        dz_next     = 1'b1;
                        done_a_next = !pick_b;
                        done_b_next = pick_b;
                    end
                end
            end
            RUN: begin
                if (!op_reg) begin
                    acc_next   = mul_sum;
                    mcand_next = {mcand_reg[2*W-2:0], 1'b0};
                    y_next     = {1'b0, y_reg[W-1:1]};
                end else begin
                    acc_next = div_quot;
                    rem_next = div_rem;
                end
                if (cnt_reg == '0) begin
                    rq_next     = op_reg ? div_quot : mul_sum;
                    rr_next     = op_reg ? div_rem : '0;
                    dz_next     = 1'b0;
                    done_a_next = !owner_reg;
                    done_b_next = owner_reg;
                    state_next  = IDLE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.ACK_A  = ack_a_reg;
    assign bus.ACK_B  = ack_b_reg;
    assign bus.DONE_A = done_a_reg;
    assign bus.DONE_B = done_b_reg;
    assign bus.RQ     = rq_reg;
    assign bus.RR     = rr_reg;
    assign bus.DZ     = dz_reg;
    assign bus.BUSY   = (state_reg == RUN);
endmodule

// File: tb/tb_k007452_arith_seq.sv
// Scoreboard bench for k007452_arith_seq: expected results are queued when a
// request is issued and compared whenever a DONE pulse appears.
module tb_k007452_arith_seq;
    localparam int W = 8;

    logic CLK = 1'b0;
    logic RES;
    always #5 CLK = ~CLK;

    k007452_arith_seq_if #(.W(W)) bus ();
    k007452_arith_seq #(.W(W)) dut (.CLK(CLK), .RES(RES), .bus(bus));

    typedef struct {
        logic        port;
        logic [15:0] rq;
        logic [7:0]  rr;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ack_cyc = 0;
    int   done_cyc = 0;
    int   done_count = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic push_expect(input logic port, input logic op, input logic [15:0] x,
                               input logic [7:0] y);
        exp_t e;
        e.port = port;
        if (!op) begin
            e.rq = {8'h00, x[7:0]} * {8'h00, y};
            e.rr = 8'h00;
            e.dz = 1'b0;
        end else if (y == 8'h00) begin
            e.rq = 16'hFFFF;
            e.rr = 8'hFF;
            e.dz = 1'b1;
        end else begin
            e.rq = x / {8'h00, y};
            e.rr = 8'(x % {8'h00, y});
            e.dz = 1'b0;
        end
        sb.push_back(e);
    endtask

    task automatic drive(input logic port, input logic req, input logic op,
                         input logic [15:0] x, input logic [7:0] y);
        if (port) begin
            bus.REQ_B = req; bus.OP_B = op; bus.X_B = x; bus.Y_B = y;
        end else begin
            bus.REQ_A = req; bus.OP_A = op; bus.X_A = x; bus.Y_A = y;
        end
    endtask

    task automatic wait_done(input string tag, input int target);
        for (int i = 0; i < 100 && done_count < target; i++) tick();
        check(tag, done_count, target);
    endtask

    // Single request from an idle unit: accept on the first edge, fixed latency.
    task automatic run_op(input string tag, input logic port, input logic op,
                          input logic [15:0] x, input logic [7:0] y);
        int   start;
        int   waited;
        logic got;
        push_expect(port, op, x, y);
        start  = done_count;
        drive(port, 1'b1, op, x, y);
        got    = 1'b0;
        waited = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            tick();
            waited++;
            got = port ? bus.ACK_B : bus.ACK_A;
        end
        check({tag, "_ack"}, got, 1);
        check({tag, "_ackwait"}, waited, 1);
        drive(port, 1'b0, op, x, y);
        wait_done({tag, "_done"}, start + 1);
        check({tag, "_lat"}, done_cyc - ack_cyc, op ? ((y == 8'h00) ? 0 : 2 * W) : W);
    endtask

    always @(posedge CLK) begin
        #1;
        cyc++;
        if (bus.ACK_A || bus.ACK_B) ack_cyc = cyc;
        if (bus.DONE_A || bus.DONE_B) begin
            done_cyc = cyc;
            done_count++;
            check("done_onehot", {31'd0, bus.DONE_A & bus.DONE_B}, 0);
            $display("txn cyc=%0d port=%s RQ=%h RR=%h DZ=%b", cyc,
                     bus.DONE_B ? "B" : "A", bus.RQ, bus.RR, bus.DZ);
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("done_port", {31'd0, bus.DONE_B}, {31'd0, mon_e.port});
                check("rq", {16'd0, bus.RQ}, {16'd0, mon_e.rq});
                check("rr", {24'd0, bus.RR}, {24'd0, mon_e.rr});
                check("dz", {31'd0, bus.DZ}, {31'd0, mon_e.dz});
            end
        end
    end

    initial begin
        int start;
        RES = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
        tick(); tick(); tick();
        check("rst_rq", {16'd0, bus.RQ}, 0);
        check("rst_rr", {24'd0, bus.RR}, 0);
        check("rst_dz", {31'd0, bus.DZ}, 0);
        check("rst_busy", {31'd0, bus.BUSY}, 0);
        check("rst_hs", {28'd0, bus.ACK_A, bus.ACK_B, bus.DONE_A, bus.DONE_B}, 0);
        RES = 1'b0;
        tick();

        // Basic multiply and divide on each port.
        run_op("t1_mul", 1'b0, 1'b0, 16'h0012, 8'h34);
        check("t1_rq_hold", {16'd0, bus.RQ}, 32'h03A8);
        run_op("t2_div", 1'b1, 1'b1, 16'h1234, 8'h56);

        // Simultaneous requests straight after reset: A first, B right after DONE_A.
        RES = 1'b1; tick(); RES = 1'b0;
        push_expect(1'b0, 1'b0, 16'h00FF, 8'hFF);
        push_expect(1'b1, 1'b1, 16'hFFFF, 8'h01);
        start = done_count;
        drive(1'b0, 1'b1, 1'b0, 16'h00FF, 8'hFF);
        drive(1'b1, 1'b1, 1'b1, 16'hFFFF, 8'h01);
        tick();
        check("t3_ack_a", {31'd0, bus.ACK_A}, 1);
        check("t3_ack_b_lose", {31'd0, bus.ACK_B}, 0);
        drive(1'b0, 1'b0, 1'b0, 16'h00FF, 8'hFF);
        check("t3_busy", {31'd0, bus.BUSY}, 1);
        wait_done("t3_done_a", start + 1);
        check("t3_lat_a", done_cyc - ack_cyc, W);
        tick();
        check("t3_ack_b", {31'd0, bus.ACK_B}, 1);
        check("t3_ack_b_cyc", ack_cyc - done_cyc, 1);
        drive(1'b1, 1'b0, 1'b1, 16'hFFFF, 8'h01);
        wait_done("t3_done_b", start + 2);
        check("t3_lat_b", done_cyc - ack_cyc, 2 * W);

        // After an A-only service a tie goes to B.
        run_op("t3_a_only", 1'b0, 1'b0, 16'h0003, 8'h05);
        push_expect(1'b1, 1'b0, 16'h0007, 8'h09);
        push_expect(1'b0, 1'b1, 16'h0100, 8'h07);
        start = done_count;
        drive(1'b0, 1'b1, 1'b1, 16'h0100, 8'h07);
        drive(1'b1, 1'b1, 1'b0, 16'h0007, 8'h09);
        tick();
        check("t3_rr_ack_b", {31'd0, bus.ACK_B}, 1);
        check("t3_rr_ack_a_lose", {31'd0, bus.ACK_A}, 0);
        drive(1'b1, 1'b0, 1'b0, 16'h0007, 8'h09);
        wait_done("t3_rr_done_b", start + 1);
        tick();
        check("t3_rr_ack_a", {31'd0, bus.ACK_A}, 1);
        drive(1'b0, 1'b0, 1'b1, 16'h0100, 8'h07);
        wait_done("t3_rr_done_a", start + 2);

        // Divide by zero: ACK and DONE together, no RUN.
        run_op("t4_dz", 1'b0, 1'b1, 16'h0100, 8'h00);
        check("t4_busy", {31'd0, bus.BUSY}, 0);

        // Reset in the middle of a multiply abandons it.
        drive(1'b0, 1'b1, 1'b0, 16'h0055, 8'h33);
        tick();
        check("t5_ack", {31'd0, bus.ACK_A}, 1);
        drive(1'b0, 1'b0, 1'b0, 16'h0055, 8'h33);
        tick(); tick();
        RES = 1'b1; tick(); RES = 1'b0;
        start = done_count;
        check("t5_rq", {16'd0, bus.RQ}, 0);
        check("t5_rr", {24'd0, bus.RR}, 0);
        check("t5_dz", {31'd0, bus.DZ}, 0);
        check("t5_busy", {31'd0, bus.BUSY}, 0);
        for (int i = 0; i < 20; i++) tick();
        check("t5_no_done", done_count - start, 0);
        run_op("t5_after", 1'b0, 1'b0, 16'h0055, 8'h33);

        // Operands are latched: changes and REQ drop mid-run have no effect.
        push_expect(1'b0, 1'b0, 16'h000F, 8'h11);
        start = done_count;
        drive(1'b0, 1'b1, 1'b0, 16'h000F, 8'h11);
        tick();
        check("t6_ack", {31'd0, bus.ACK_A}, 1);
        tick();
        drive(1'b0, 1'b0, 1'b1, 16'hABCD, 8'hCD);
        tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        wait_done("t6_done", start + 1);
        check("t6_lat", done_cyc - ack_cyc, W);

        // A few random operations on alternating ports.
        for (int i = 0; i < 8; i++) begin
            run_op("rnd", 1'(i), 1'($urandom_range(0, 1)), 16'($urandom),
                   (i == 5) ? 8'h00 : 8'($urandom_range(1, 255)));
        end

        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
